// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared key codes, ALU opcodes and sequencer states
// Imported by the sequencer, its accumulators and the ALU that consumes the opcodes.
package calc_pkg;

    localparam int MAX_DIGITS_DEFAULT = 9;

    localparam logic [4:0] KEY_ADD   = 5'h10;
    localparam logic [4:0] KEY_SUB   = 5'h11;
    localparam logic [4:0] KEY_MUL   = 5'h12;
    localparam logic [4:0] KEY_DIV   = 5'h13;
    localparam logic [4:0] KEY_EQUAL = 5'h14;
    localparam logic [4:0] KEY_CLEAR = 5'h15;

    localparam logic [3:0] OPC_IDLE = 4'b0000;
    localparam logic [3:0] OPC_DIV  = 4'b0001;
    localparam logic [3:0] OPC_MUL  = 4'b0010;
    localparam logic [3:0] OPC_SUB  = 4'b0100;
    localparam logic [3:0] OPC_ADD  = 4'b1000;

    typedef enum logic [2:0] {
        ST_OP1,
        ST_OP2,
        ST_ISSUE,
        ST_WAIT,
        ST_SHOW,
        ST_ERR
    } state_t;

    function automatic logic key_is_operator(input logic [4:0] key);
        return (key == KEY_ADD) || (key == KEY_SUB) || (key == KEY_MUL) || (key == KEY_DIV);
    endfunction

    function automatic logic [3:0] key_opcode(input logic [4:0] key);
        case (key)
            KEY_ADD: return OPC_ADD;
            KEY_SUB: return OPC_SUB;
            KEY_MUL: return OPC_MUL;
            KEY_DIV: return OPC_DIV;
            default: return OPC_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// rtl/calc_sequencer_if.sv - keypad input plus ALU operand/opcode/result bundle
// The sequencer is the master (initiator); the keypad/ALU side is the slave.
interface calc_sequencer_if;

    logic        _key_valid;
    logic [4:0]  _key_code;
    logic [31:0] _alu_result;
    logic [31:0] _alu_op1;
    logic [31:0] _alu_op2;
    logic [3:0]  _alu_opcao;
    logic [31:0] _display;
    logic        _busy;
    logic        _done;
    logic        _error;

    modport master (
        input  _key_valid,
        input  _key_code,
        input  _alu_result,
        output _alu_op1,
        output _alu_op2,
        output _alu_opcao,
        output _display,
        output _busy,
        output _done,
        output _error
    );

    modport slave (
        output _key_valid,
        output _key_code,
        output _alu_result,
        input  _alu_op1,
        input  _alu_op2,
        input  _alu_opcao,
        input  _display,
        input  _busy,
        input  _done,
        input  _error
    );

endinterface

// File: rtl/calc_digit_acc.sv
// rtl/calc_digit_acc.sv - decimal operand accumulator (x10 + d) with digit counter
// Digits beyond MAX_DIGITS are dropped so the value always fits in 32 bits.
module calc_digit_acc #(
    parameter int MAX_DIGITS = 9
) (
    input  logic                              _clock,
    input  logic                              _reset_n,
    input  logic                              clear,
    input  logic                              load,
    input  logic [31:0]                       load_value,
    input  logic [$clog2(MAX_DIGITS+1)-1:0]   load_count,
    input  logic                              digit_strobe,
    input  logic [3:0]                        digit,
    output logic [31:0]                       value,
    output logic                              empty
);

    localparam int CW = $clog2(MAX_DIGITS + 1);

    logic [CW-1:0] count;

    // Priority: clear, then load, then digit entry.
    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            value <= '0;
            count <= '0;
        end else if (clear) begin
            value <= '0;
            count <= '0;
        end else if (load) begin
            value <= load_value;
            count <= load_count;
        end else if (digit_strobe && (count < CW'(MAX_DIGITS))) begin
            value <= value * 32'd10 + {28'd0, digit};
            count <= count + 1'b1;
        end
    end

    assign empty = (count == '0);

endmodule

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - keypad-to-ALU control FSM for the calculator datapath
// Builds two operands, issues a one-cycle one-hot opcode, captures the ALU result.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS = MAX_DIGITS_DEFAULT
) (
    input  logic              _clock,
    input  logic              _reset_n,
    calc_sequencer_if.master  bus
);

    localparam int CW = $clog2(MAX_DIGITS + 1);

    state_t      state_q, state_d;
    logic [3:0]  opc_q, opc_d;
    logic [31:0] alu_op1_q, alu_op1_d;
    logic [31:0] alu_op2_q, alu_op2_d;
    logic [3:0]  alu_opcao_q, alu_opcao_d;
    logic [31:0] result_q, result_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic [31:0] op1_value, op2_value;
    logic        op1_empty_unused, op2_empty;
    logic        op1_clear, op1_load, op1_digit_strobe;
    logic [31:0] op1_load_value;
    logic [CW-1:0] op1_load_count;
    logic        op2_clear, op2_digit_strobe;

    logic        busy;
    logic        accept;
    logic        key_is_digit;
    logic        key_is_oper;
    logic [3:0]  key_digit;

    assign busy         = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign accept       = bus._key_valid && !busy;
    assign key_is_digit = (bus._key_code <= 5'd9);
    assign key_is_oper  = key_is_operator(bus._key_code);
    assign key_digit    = bus._key_code[3:0];

    calc_digit_acc #(.MAX_DIGITS(MAX_DIGITS)) u_op1_acc (
        ._clock       (_clock),
        ._reset_n     (_reset_n),
        .clear        (op1_clear),
        .load         (op1_load),
        .load_value   (op1_load_value),
        .load_count   (op1_load_count),
        .digit_strobe (op1_digit_strobe),
        .digit        (key_digit),
        .value        (op1_value),
        .empty        (op1_empty_unused)
    );

    calc_digit_acc #(.MAX_DIGITS(MAX_DIGITS)) u_op2_acc (
        ._clock       (_clock),
        ._reset_n     (_reset_n),
        .clear        (op2_clear),
        .load         (1'b0),
        .load_value   (32'd0),
        .load_count   ('0),
        .digit_strobe (op2_digit_strobe),
        .digit        (key_digit),
        .value        (op2_value),
        .empty        (op2_empty)
    );

    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            state_q     <= ST_OP1;
            opc_q       <= OPC_IDLE;
            alu_op1_q   <= '0;
            alu_op2_q   <= '0;
            alu_opcao_q <= OPC_IDLE;
            result_q    <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            opc_q       <= opc_d;
            alu_op1_q   <= alu_op1_d;
            alu_op2_q   <= alu_op2_d;
            alu_opcao_q <= alu_opcao_d;
            result_q    <= result_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        opc_d            = opc_q;
        alu_op1_d        = alu_op1_q;
        alu_op2_d        = alu_op2_q;
        alu_opcao_d      = OPC_IDLE;
        result_d         = result_q;
        done_d           = 1'b0;
        error_d          = error_q;
        op1_clear        = 1'b0;
        op1_load         = 1'b0;
        op1_load_value   = '0;
        op1_load_count   = '0;
        op1_digit_strobe = 1'b0;
        op2_clear        = 1'b0;
        op2_digit_strobe = 1'b0;

        case (state_q)
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                state_d  = ST_SHOW;
                result_d = bus._alu_result;
                done_d   = 1'b1;
            end
            default: begin
                if (accept && (bus._key_code == KEY_CLEAR)) begin
                    op1_clear = 1'b1;
                    op2_clear = 1'b1;
                    error_d   = 1'b0;
                    state_d   = ST_OP1;
                end else if (accept) begin
                    case (state_q)
                        ST_OP1: begin
                            if (key_is_digit) begin
                                op1_digit_strobe = 1'b1;
                            end else if (key_is_oper) begin
                                opc_d     = key_opcode(bus._key_code);
                                op2_clear = 1'b1;
                                state_d   = ST_OP2;
                            end
                        end
                        ST_OP2: begin
                            if (key_is_digit) begin
                                op2_digit_strobe = 1'b1;
                            end else if (key_is_oper && op2_empty) begin
                                opc_d = key_opcode(bus._key_code);
                            end else if (bus._key_code == KEY_EQUAL) begin
                                if ((opc_q == OPC_DIV) && (op2_value == '0)) begin
                                    error_d = 1'b1;
                                    state_d = ST_ERR;
                                end else begin
                                    alu_op1_d   = op1_value;
                                    alu_op2_d   = op2_value;
                                    alu_opcao_d = opc_q;
                                    state_d     = ST_ISSUE;
                                end
                            end
                        end
                        ST_SHOW: begin
                            // Operator chains on the previous result; a digit starts afresh.
                            if (key_is_oper) begin
                                op1_load       = 1'b1;
                                op1_load_value = result_q;
                                op2_clear      = 1'b1;
                                opc_d          = key_opcode(bus._key_code);
                                state_d        = ST_OP2;
                            end else if (key_is_digit) begin
                                op1_load       = 1'b1;
                                op1_load_value = {28'd0, key_digit};
                                op1_load_count = CW'(1);
                                op2_clear      = 1'b1;
                                state_d        = ST_OP1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        case (state_q)
            ST_OP1:  bus._display = op1_value;
            ST_SHOW: bus._display = result_q;
            ST_ERR:  bus._display = 32'hFFFF_FFFF;
            default: bus._display = op2_value;
        endcase
    end

    assign bus._alu_op1   = alu_op1_q;
    assign bus._alu_op2   = alu_op2_q;
    assign bus._alu_opcao = alu_opcao_q;
    assign bus._busy      = busy;
    assign bus._done      = done_q;
    assign bus._error     = error_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - directed and randomized key sequences against a calculator model
// A registered ALU lives here; expected display/flags come from an arithmetic model.
module tb_calc_sequencer;
    import calc_pkg::*;

    localparam logic [4:0] K_DIV   = 5'h13;
    localparam logic [4:0] K_EQUAL = 5'h14;
    localparam logic [4:0] K_CLEAR = 5'h15;

    logic clock = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   failures = 0;

    calc_sequencer_if bus();

    calc_sequencer #(.MAX_DIGITS(9)) dut (
        ._clock   (clock),
        ._reset_n (reset_n),
        .bus      (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        case (bus._alu_opcao)
            OPC_ADD: bus._alu_result <= bus._alu_op1 + bus._alu_op2;
            OPC_SUB: bus._alu_result <= bus._alu_op1 - bus._alu_op2;
            OPC_MUL: bus._alu_result <= bus._alu_op1 * bus._alu_op2;
            OPC_DIV: bus._alu_result <= (bus._alu_op2 == 0) ? 32'd0 : bus._alu_op1 / bus._alu_op2;
            default: ;
        endcase
    end

    // Calculator model: mode 1 entering op1, 2 entering op2, 3 showing result, 4 error.
    int          m_mode;
    logic [31:0] m_op1, m_op2, m_res;
    int          m_n1, m_n2;
    logic [4:0]  m_opc;
    bit          m_err;

    task automatic model_reset();
        m_mode = 1; m_op1 = 0; m_op2 = 0; m_res = 0;
        m_n1 = 0; m_n2 = 0; m_opc = 5'h10; m_err = 0;
    endtask

    function automatic logic [31:0] arith(input logic [4:0] k, input logic [31:0] a, input logic [31:0] b);
        case (k)
            5'h10:   return a + b;
            5'h11:   return a - b;
            5'h12:   return a * b;
            default: return a / b;
        endcase
    endfunction

    function automatic logic [3:0] onehot(input logic [4:0] k);
        int sh;
        sh = 3 - (int'(k) - 16);
        return 4'(1 << sh);
    endfunction

    function automatic logic [31:0] m_display();
        case (m_mode)
            1:       return m_op1;
            2:       return m_op2;
            3:       return m_res;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic bit will_issue(input logic [4:0] k);
        return (m_mode == 2) && (k == K_EQUAL) && !((m_opc == K_DIV) && (m_op2 == 0));
    endfunction

    task automatic model_key(input logic [4:0] k);
        bit is_digit, is_op;
        is_digit = (k <= 5'd9);
        is_op    = (k >= 5'h10) && (k <= 5'h13);
        if (k == K_CLEAR) begin
            m_op1 = 0; m_op2 = 0; m_n1 = 0; m_n2 = 0; m_err = 0; m_mode = 1;
        end else if (m_mode == 1) begin
            if (is_digit && m_n1 < 9) begin m_op1 = m_op1 * 10 + 32'(k); m_n1++; end
            else if (is_op) begin m_opc = k; m_op2 = 0; m_n2 = 0; m_mode = 2; end
        end else if (m_mode == 2) begin
            if (is_digit && m_n2 < 9) begin m_op2 = m_op2 * 10 + 32'(k); m_n2++; end
            else if (is_op && m_n2 == 0) m_opc = k;
            else if (k == K_EQUAL) begin
                if (m_opc == K_DIV && m_op2 == 0) begin m_mode = 4; m_err = 1; end
                else begin m_res = arith(m_opc, m_op1, m_op2); m_mode = 3; end
            end
        end else if (m_mode == 3) begin
            if (is_op) begin m_op1 = m_res; m_opc = k; m_op2 = 0; m_n2 = 0; m_mode = 2; end
            else if (is_digit) begin m_op1 = 32'(k); m_n1 = 1; m_mode = 1; end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [4:0] k);
        @(negedge clock);
        bus._key_valid = 1'b1;
        bus._key_code  = k;
        @(posedge clock);
        #1;
        bus._key_valid = 1'b0;
    endtask

    task automatic do_key(input logic [4:0] k, input string tag);
        logic [31:0] e1, e2;
        logic [3:0]  eo;
        bit          issue;
        issue = will_issue(k);
        e1 = m_op1; e2 = m_op2; eo = onehot(m_opc);
        model_key(k);
        press(k);
        @(negedge clock);
        if (issue) begin
            check({tag, "_issue_busy"}, 32'(bus._busy), 32'd1);
            check({tag, "_issue_opc"}, 32'(bus._alu_opcao), 32'(eo));
            check({tag, "_issue_op1"}, bus._alu_op1, e1);
            check({tag, "_issue_op2"}, bus._alu_op2, e2);
            @(negedge clock);
            check({tag, "_wait_opc"}, 32'(bus._alu_opcao), 32'd0);
            check({tag, "_wait_busy"}, 32'(bus._busy), 32'd1);
            check({tag, "_wait_done"}, 32'(bus._done), 32'd0);
            @(negedge clock);
            check({tag, "_show_done"}, 32'(bus._done), 32'd1);
            check({tag, "_show_busy"}, 32'(bus._busy), 32'd0);
            check({tag, "_show_disp"}, bus._display, m_display());
        end else begin
            check({tag, "_disp"}, bus._display, m_display());
            check({tag, "_err"}, 32'(bus._error), 32'(m_err));
            check({tag, "_done"}, 32'(bus._done), 32'd0);
            check({tag, "_busy"}, 32'(bus._busy), 32'd0);
            check({tag, "_opc"}, 32'(bus._alu_opcao), 32'd0);
        end
    endtask

    function automatic logic [4:0] rand_key();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 55)      return 5'($urandom_range(0, 9));
        else if (r < 75) return 5'(16 + $urandom_range(0, 3));
        else if (r < 88) return K_EQUAL;
        else if (r < 93) return K_CLEAR;
        else if (r < 97) return 5'(10 + $urandom_range(0, 5));
        else             return 5'h1F;
    endfunction

    initial begin
        bus._key_valid = 1'b0;
        bus._key_code  = 5'd0;
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        check("rst_disp", bus._display, 32'd0);
        check("rst_op1", bus._alu_op1, 32'd0);
        check("rst_op2", bus._alu_op2, 32'd0);
        check("rst_opc", 32'(bus._alu_opcao), 32'd0);
        check("rst_busy", 32'(bus._busy), 32'd0);
        check("rst_done", 32'(bus._done), 32'd0);
        check("rst_err", 32'(bus._error), 32'd0);
        reset_n = 1'b1;

        do_key(5'd1, "t1"); do_key(5'd2, "t1"); do_key(5'h10, "t1");
        do_key(5'd3, "t1"); do_key(5'd0, "t1"); do_key(K_EQUAL, "t1_eq");
        check("t1_result", bus._display, 32'd42);

        do_key(K_CLEAR, "t2"); do_key(5'd5, "t2"); do_key(5'h11, "t2");
        do_key(5'd9, "t2"); do_key(K_EQUAL, "t2_eq");
        check("t2_wrap", bus._display, 32'hFFFF_FFFC);
        do_key(5'h12, "t2c"); do_key(5'd2, "t2c"); do_key(K_EQUAL, "t2c_eq");
        check("t2_chain", bus._display, 32'hFFFF_FFF8);

        do_key(K_CLEAR, "t3"); do_key(5'd7, "t3"); do_key(K_DIV, "t3");
        do_key(5'd0, "t3"); do_key(K_EQUAL, "t3_eq");
        check("t3_err", 32'(bus._error), 32'd1);
        check("t3_disp", bus._display, 32'hFFFF_FFFF);
        @(negedge clock);
        check("t3_no_issue", 32'(bus._alu_opcao), 32'd0);
        do_key(5'd3, "t3_ign"); do_key(5'h10, "t3_ign"); do_key(K_EQUAL, "t3_ign");
        do_key(K_CLEAR, "t3_clr");
        check("t3_clr_err", 32'(bus._error), 32'd0);
        check("t3_clr_disp", bus._display, 32'd0);

        do_key(K_CLEAR, "t4");
        for (int i = 0; i < 10; i++) do_key(5'd9, "t4_nine");
        check("t4_sat", bus._display, 32'd999999999);
        do_key(5'h10, "t4"); do_key(5'h10, "t4"); do_key(5'h11, "t4");
        do_key(5'd1, "t4"); do_key(K_EQUAL, "t4_eq");
        check("t4_result", bus._display, 32'd999999998);

        do_key(K_CLEAR, "t5"); do_key(5'd4, "t5"); do_key(5'h10, "t5"); do_key(5'd5, "t5");
        model_key(K_EQUAL);
        press(K_EQUAL);
        @(negedge clock);
        check("t5_issue_busy", 32'(bus._busy), 32'd1);
        bus._key_valid = 1'b1;
        bus._key_code  = 5'd8;
        @(negedge clock);
        check("t5_wait_busy", 32'(bus._busy), 32'd1);
        @(negedge clock);
        bus._key_valid = 1'b0;
        check("t5_done", 32'(bus._done), 32'd1);
        check("t5_disp", bus._display, 32'd9);
        @(negedge clock);
        check("t5_dropped", bus._display, m_display());
        check("t5_done_clr", 32'(bus._done), 32'd0);

        do_key(K_CLEAR, "t6"); do_key(5'd2, "t6"); do_key(5'h12, "t6"); do_key(5'd3, "t6");
        press(K_EQUAL);
        @(negedge clock);
        check("t6_issue_opc", 32'(bus._alu_opcao), 32'b0010);
        @(negedge clock);
        check("t6_wait_busy", 32'(bus._busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_disp", bus._display, 32'd0);
        check("t6_rst_op1", bus._alu_op1, 32'd0);
        check("t6_rst_op2", bus._alu_op2, 32'd0);
        check("t6_rst_opc", 32'(bus._alu_opcao), 32'd0);
        check("t6_rst_busy", 32'(bus._busy), 32'd0);
        check("t6_rst_done", 32'(bus._done), 32'd0);
        @(negedge clock);
        check("t6_no_done", 32'(bus._done), 32'd0);
        check("t6_hold_disp", bus._display, 32'd0);
        reset_n = 1'b1;
        model_reset();
        do_key(5'd5, "t6_after");

        for (int i = 0; i < 300; i++) do_key(rand_key(), "rnd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
